// File: rtl/pipeline_ctrl.sv
// Hazard controller for the 5-stage pipeline: PC redirect, load-use stall
// sequencing and post-redirect flush windows.
module pipeline_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_pc_jump,
  input  logic [XLEN-1:0] ex_pc_jump_addr,
  input  logic            ex_mem_load_en,
  input  logic [4:0]      ex_mem_load_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_rs1_en,
  input  logic            id_rs2_en,
  input  logic            mem_load_done,
  output logic            pc_set_en,
  output logic [XLEN-1:0] pc_set_addr,
  output logic            pc_hold,
  output logic            if_id_hold,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            misalign_err,
  output logic            load_timeout_err
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_LIM = 9'(LOAD_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hazard;

  assign hazard = ex_mem_load_en && (ex_mem_load_rd != 5'd0) &&
                  ((id_rs1_en && (id_rs1 == ex_mem_load_rd)) ||
                   (id_rs2_en && (id_rs2 == ex_mem_load_rd)));

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pc_set_en        = 1'b0;
    pc_set_addr      = '0;
    pc_hold          = 1'b0;
    if_id_hold       = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    misalign_err     = 1'b0;
    load_timeout_err = 1'b0;

    case (state_q)
      RUN: begin
        // A redirect squashes the younger decode instruction, so it beats any hazard.
        if (ex_pc_jump) begin
          if (ex_pc_jump_addr[1:0] == 2'b00) begin
            pc_set_en   = 1'b1;
            pc_set_addr = ex_pc_jump_addr;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end else begin
            misalign_err = 1'b1;
          end
        end else if (hazard) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = LOAD_WAIT;
          cnt_d       = 8'd0;
        end
      end

      LOAD_WAIT: begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
        // The stall cycle spent in RUN counts toward the timeout budget.
        if (mem_load_done) begin
          state_d = RUN;
        end else if ({1'b0, cnt_q} + 9'd2 >= TIMEOUT_LIM) begin
          load_timeout_err = 1'b1;
          state_d          = RUN;
          cnt_d            = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        cnt_d       = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase

    // Reset silences every output in the same cycle it is asserted.
    if (rst) begin
      pc_set_en        = 1'b0;
      pc_set_addr      = '0;
      pc_hold          = 1'b0;
      if_id_hold       = 1'b0;
      if_id_flush      = 1'b0;
      id_ex_flush      = 1'b0;
      misalign_err     = 1'b0;
      load_timeout_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int LOAD_TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_pc_jump;
  logic [XLEN-1:0] ex_pc_jump_addr;
  logic            ex_mem_load_en;
  logic [4:0]      ex_mem_load_rd;
  logic [4:0]      id_rs1, id_rs2;
  logic            id_rs1_en, id_rs2_en;
  logic            mem_load_done;
  logic            pc_set_en;
  logic [XLEN-1:0] pc_set_addr;
  logic            pc_hold, if_id_hold, if_id_flush, id_ex_flush;
  logic            misalign_err, load_timeout_err;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_pc_jump(ex_pc_jump), .ex_pc_jump_addr(ex_pc_jump_addr),
    .ex_mem_load_en(ex_mem_load_en), .ex_mem_load_rd(ex_mem_load_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .mem_load_done(mem_load_done),
    .pc_set_en(pc_set_en), .pc_set_addr(pc_set_addr),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .misalign_err(misalign_err), .load_timeout_err(load_timeout_err)
  );

  typedef struct packed {
    logic            set_en;
    logic [XLEN-1:0] addr;
    logic            pc_hold;
    logic            if_id_hold;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            mis;
    logic            tmo;
  } exp_t;

  exp_t expq[$];
  string nameq[$];
  int compared   = 0;
  int mismatched = 0;

  // Model state: flush cycles still owed after a redirect, and how long the
  // current load-use stall has been waiting (-1 when not stalled).
  int flush_owed = 0;
  int wait_age   = -1;

  task automatic cyc(input string nm, input logic r, input logic j,
                     input logic [XLEN-1:0] a, input logic le, input logic [4:0] rd,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic e1, input logic e2, input logic d);
    exp_t e;
    logic hz;
    rst = r; ex_pc_jump = j; ex_pc_jump_addr = a;
    ex_mem_load_en = le; ex_mem_load_rd = rd;
    id_rs1 = s1; id_rs2 = s2; id_rs1_en = e1; id_rs2_en = e2;
    mem_load_done = d;
    e = '0;
    hz = le && rd != 0 && ((e1 && s1 == rd) || (e2 && s2 == rd));
    if (r) begin
      flush_owed = 0;
      wait_age   = -1;
    end else if (flush_owed > 0) begin
      e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
      flush_owed--;
    end else if (wait_age >= 0) begin
      e.pc_hold = 1'b1; e.if_id_hold = 1'b1; e.id_ex_flush = 1'b1;
      if (d) wait_age = -1;
      else if (wait_age + 2 >= LOAD_TIMEOUT) begin
        e.tmo = 1'b1;
        wait_age = -1;
      end else wait_age++;
    end else if (j) begin
      if (a[1:0] == 2'b00) begin
        e.set_en = 1'b1; e.addr = a;
        e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
        flush_owed = FLUSH_CYCLES - 1;
      end else e.mis = 1'b1;
    end else if (hz) begin
      e.pc_hold = 1'b1; e.if_id_hold = 1'b1; e.id_ex_flush = 1'b1;
      wait_age = 0;
    end
    expq.push_back(e);
    nameq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++)
      cyc(nm, 1'b0, 1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    string nm;
    if (expq.size() > 0) begin
      e  = expq.pop_front();
      nm = nameq.pop_front();
      g  = {pc_set_en, pc_set_addr, pc_hold, if_id_hold, if_id_flush,
            id_ex_flush, misalign_err, load_timeout_err};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: got set=%0b addr=%h hold=%0b%0b flush=%0b%0b mis=%0b tmo=%0b, expected set=%0b addr=%h hold=%0b%0b flush=%0b%0b mis=%0b tmo=%0b",
                 nm, g.set_en, g.addr, g.pc_hold, g.if_id_hold, g.if_id_flush, g.id_ex_flush, g.mis, g.tmo,
                 e.set_en, e.addr, e.pc_hold, e.if_id_hold, e.if_id_flush, e.id_ex_flush, e.mis, e.tmo);
      end
      compared++;
      if ((pc_hold && pc_set_en) || (if_id_hold && if_id_flush)) begin
        mismatched++;
        $display("FAIL %s_exclusive: got pc_hold=%0b pc_set_en=%0b if_id_hold=%0b if_id_flush=%0b, expected no hold/set or hold/flush overlap",
                 nm, pc_hold, pc_set_en, if_id_hold, if_id_flush);
      end
    end
  end

  initial begin
    logic [XLEN-1:0] a;
    rst = 1'b1; ex_pc_jump = 1'b0; ex_pc_jump_addr = '0;
    ex_mem_load_en = 1'b0; ex_mem_load_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_en = 1'b0; id_rs2_en = 1'b0; mem_load_done = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++)
      cyc("reset", 1'b1, 1'b1, 32'h100, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    idle("post_reset", 1);

    cyc("jump", 1'b0, 1'b1, 32'h0000_0100, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("flush1", 1'b0, 1'b1, 32'h0000_0200, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    idle("after_flush", 2);

    cyc("lu_start", 1'b0, 1'b0, '0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
    cyc("lu_wait1", 1'b0, 1'b1, 32'h40, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc("lu_wait2", 1'b0, 1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
    cyc("lu_done", 1'b0, 1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1);
    idle("lu_release", 1);
    cyc("lu_x0", 1'b0, 1'b0, '0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    idle("done_outside", 0);
    cyc("done_in_run", 1'b0, 1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    cyc("tmo_start", 1'b0, 1'b0, '0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
    idle("tmo_wait", 14);
    idle("tmo_after", 2);

    cyc("misalign", 1'b0, 1'b1, 32'h0000_0102, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("jump_vs_hz", 1'b0, 1'b1, 32'h0000_0200, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    idle("jump_vs_hz_tail", 2);

    cyc("rst_lw_start", 1'b0, 1'b0, '0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
    idle("rst_lw_wait1", 1);
    cyc("rst_lw_rst", 1'b1, 1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle("rst_lw_after", 2);

    for (int i = 0; i < 600; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      cyc("random", ($urandom_range(63) == 0), ($urandom_range(7) == 0), a,
          ($urandom_range(2) == 0), 5'($urandom_range(3)),
          5'($urandom_range(3)), 5'($urandom_range(3)),
          1'($urandom_range(1)), 1'($urandom_range(1)),
          ($urandom_range(5) == 0));
    end

    for (int i = 0; i < 4 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending entries, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
